// File: rtl/tlb_lookup_unit.sv
// tlb_lookup_unit: registered MIPS-style joint TLB with lookup, TLBWI/TLBWR, TLBP, TLBR and Wired-aware Random
module tlb_lookup_unit #(
    parameter int ENTRIES = 16,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookupReq,
    input  logic [31:0]      virtAddr,
    input  logic [7:0]       nowASID,
    output logic             respValid,
    output logic [31:0]      phyAddr,
    output logic             miss,
    output logic             valid,
    output logic             dirt,
    output logic             bypassCache,
    output logic [IDX_W-1:0] matchWhich,
    input  logic             wrEn,
    input  logic             wrRandom,
    input  logic [IDX_W-1:0] wrIndex,
    input  logic [85:0]      wrEntry,
    input  logic             probeReq,
    input  logic [26:0]      probeHi,
    output logic             probeDone,
    output logic             probeMiss,
    output logic [IDX_W-1:0] probeIndex,
    input  logic             rdReq,
    input  logic [IDX_W-1:0] rdIndex,
    output logic             rdDone,
    output logic [85:0]      rdEntry,
    input  logic [IDX_W-1:0] wired,
    output logic [IDX_W-1:0] randomIdx
);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(ENTRIES - 1);

    logic [85:0]        mem [ENTRIES];
    logic [ENTRIES-1:0] present;
    logic               lk_hit, pb_hit, page;
    logic [IDX_W-1:0]   lk_idx, pb_idx, wr_tgt;
    logic [23:0]        pfn;
    logic [2:0]         cf;

    // descending scan so the lowest matching index is the last one assigned
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        pb_hit = 1'b0;
        pb_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (present[i] && mem[i][70:52] == virtAddr[31:13] && (mem[i][79:72] == nowASID || mem[i][71])) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (present[i] && mem[i][70:52] == probeHi[18:0] && (mem[i][79:72] == probeHi[26:19] || mem[i][71])) begin
                pb_hit = 1'b1;
                pb_idx = IDX_W'(i);
            end
        end
    end

    assign page   = virtAddr[12];
    assign pfn    = page ? mem[lk_idx][51:28] : mem[lk_idx][25:2];
    assign cf     = page ? mem[lk_idx][82:80] : mem[lk_idx][85:83];
    assign wr_tgt = wrRandom ? randomIdx : wrIndex;

    always_ff @(posedge clk) begin
        if (rst) begin
            present <= '0;
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else if (wrEn) begin
            present[wr_tgt] <= 1'b1;
            mem[wr_tgt]     <= wrEntry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) randomIdx <= TOP;
        else randomIdx <= (randomIdx <= wired) ? TOP : randomIdx - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            respValid   <= 1'b0;
            phyAddr     <= '0;
            miss        <= 1'b1;
            valid       <= 1'b0;
            dirt        <= 1'b0;
            bypassCache <= 1'b0;
            matchWhich  <= '0;
        end else begin
            respValid <= lookupReq;
            if (lookupReq) begin
                phyAddr     <= {lk_hit ? pfn[19:0] : 20'b0, virtAddr[11:0]};
                miss        <= ~lk_hit;
                valid       <= lk_hit & (page ? mem[lk_idx][26] : mem[lk_idx][0]);
                dirt        <= lk_hit & (page ? mem[lk_idx][27] : mem[lk_idx][1]);
                bypassCache <= lk_hit & (cf == 3'd2);
                matchWhich  <= lk_hit ? lk_idx : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            probeDone  <= 1'b0;
            probeMiss  <= 1'b1;
            probeIndex <= '0;
            rdDone     <= 1'b0;
            rdEntry    <= '0;
        end else begin
            probeDone <= probeReq;
            rdDone    <= rdReq;
            if (probeReq) begin
                probeMiss  <= ~pb_hit;
                probeIndex <= pb_idx;
            end
            if (rdReq) rdEntry <= mem[rdIndex];
        end
    end
endmodule

// File: tb/tb_tlb_lookup_unit.sv
// tb_tlb_lookup_unit: directed vectors with hand-computed expectations for tlb_lookup_unit
module tb_tlb_lookup_unit;
    logic        clk = 0, rst = 1;
    logic        lookupReq = 0, respValid, miss, valid, dirt, bypassCache;
    logic [31:0] virtAddr = 0, phyAddr;
    logic [7:0]  nowASID = 0;
    logic [3:0]  matchWhich, wrIndex = 0, probeIndex, rdIndex = 0, wired = 0, randomIdx;
    logic        wrEn = 0, wrRandom = 0, probeReq = 0, probeDone, probeMiss, rdReq = 0, rdDone;
    logic [85:0] wrEntry = 0, rdEntry;
    logic [26:0] probeHi = 0;
    int total = 0, bad = 0;

    localparam logic [85:0] E3  = {3'd2, 3'd0, 8'd5, 1'b0, 19'h40, 24'h0, 1'b0, 1'b0, 24'h12345, 1'b1, 1'b1};
    localparam logic [85:0] EG  = {3'd0, 3'd3, 8'd0, 1'b1, 19'h100, 24'h0ABCD, 1'b0, 1'b1, 24'h00777, 1'b1, 1'b0};
    localparam logic [85:0] E7  = {3'd3, 3'd3, 8'd9, 1'b0, 19'h2AA, 24'h0, 1'b0, 1'b0, 24'h0BEEF, 1'b0, 1'b1};
    localparam logic [85:0] EX  = {3'd1, 3'd2, 8'hA5, 1'b1, 19'h12345, 24'hABCDEF, 1'b1, 1'b0, 24'h654321, 1'b0, 1'b1};

    always #5 clk = ~clk;

    tlb_lookup_unit #(.ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .lookupReq(lookupReq), .virtAddr(virtAddr), .nowASID(nowASID),
        .respValid(respValid), .phyAddr(phyAddr), .miss(miss), .valid(valid), .dirt(dirt),
        .bypassCache(bypassCache), .matchWhich(matchWhich), .wrEn(wrEn), .wrRandom(wrRandom),
        .wrIndex(wrIndex), .wrEntry(wrEntry), .probeReq(probeReq), .probeHi(probeHi),
        .probeDone(probeDone), .probeMiss(probeMiss), .probeIndex(probeIndex), .rdReq(rdReq),
        .rdIndex(rdIndex), .rdDone(rdDone), .rdEntry(rdEntry), .wired(wired), .randomIdx(randomIdx)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [85:0] got, input logic [85:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write(input logic [3:0] idx, input logic [85:0] e);
        wrEn = 1; wrRandom = 0; wrIndex = idx; wrEntry = e;
        tick;
        wrEn = 0;
    endtask

    task automatic lookup(input logic [31:0] a, input logic [7:0] asid);
        lookupReq = 1; virtAddr = a; nowASID = asid;
        tick;
        lookupReq = 0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_resp", respValid, 0);
        chk("rst_miss", miss, 1);
        chk("rst_pmiss", probeMiss, 1);
        chk("rst_phy", phyAddr, 0);
        chk("rst_rnd", randomIdx, 15);
        rst = 0;
        lookup(32'h0, 8'd0);
        chk("zero_resp", respValid, 1);
        chk("zero_miss", miss, 1);

        write(4'd3, E3);
        lookup(32'h00080ABC, 8'd5);
        chk("wi_miss", miss, 0);
        chk("wi_phy", phyAddr, 32'h12345ABC);
        chk("wi_v", valid, 1);
        chk("wi_d", dirt, 1);
        chk("wi_c", bypassCache, 1);
        chk("wi_idx", matchWhich, 3);
        lookup(32'h00080ABC, 8'd6);
        chk("asid_miss", miss, 1);
        chk("asid_phy", phyAddr, 32'h00000ABC);
        chk("asid_idx", matchWhich, 0);
        chk("asid_v", valid, 0);
        tick;
        chk("hold_resp", respValid, 0);
        chk("hold_phy", phyAddr, 32'h00000ABC);

        write(4'd9, EG);
        write(4'd2, EG);
        lookup(32'h00201123, 8'h77);
        chk("g_odd_idx", matchWhich, 2);
        chk("g_odd_phy", phyAddr, 32'h0ABCD123);
        chk("g_odd_v", valid, 1);
        chk("g_odd_d", dirt, 0);
        chk("g_odd_c", bypassCache, 0);
        lookup(32'h00200456, 8'h01);
        chk("g_even_idx", matchWhich, 2);
        chk("g_even_phy", phyAddr, 32'h00777456);
        chk("g_even_v", valid, 0);
        chk("g_even_d", dirt, 1);

        wrEn = 1; wrIndex = 4'd7; wrEntry = E7;
        probeReq = 1; probeHi = {8'd9, 19'h2AA};
        lookupReq = 1; virtAddr = 32'h00554000; nowASID = 8'd9;
        tick;
        wrEn = 0;
        chk("same_pdone", probeDone, 1);
        chk("same_pmiss", probeMiss, 1);
        chk("same_miss", miss, 1);
        tick;
        probeReq = 0; lookupReq = 0;
        chk("next_pmiss", probeMiss, 0);
        chk("next_pidx", probeIndex, 7);
        chk("next_miss", miss, 0);
        chk("next_phy", phyAddr, 32'h0BEEF000);
        chk("next_idx", matchWhich, 7);

        lookup(32'h00201123, 8'h00);
        chk("pre_rst_resp", respValid, 1);
        rst = 1; wired = 4'd4;
        wrEn = 1; wrIndex = 4'd5; wrEntry = EX;
        tick;
        rst = 0; wrEn = 0;
        chk("mid_resp", respValid, 0);
        chk("mid_miss", miss, 1);
        chk("mid_phy", phyAddr, 0);
        chk("mid_idx", matchWhich, 0);
        chk("mid_v", valid, 0);
        chk("mid_pmiss", probeMiss, 1);
        chk("mid_rnd", randomIdx, 15);
        for (int k = 14; k >= 4; k--) begin
            tick;
            chk("rnd_seq", randomIdx, k);
        end
        tick;
        chk("rnd_wrap", randomIdx, 15);
        tick;
        chk("rnd_14", randomIdx, 14);
        wrEn = 1; wrRandom = 1; wrIndex = 4'd0; wrEntry = EX;
        tick;
        wrEn = 0; wrRandom = 0;
        rdReq = 1; rdIndex = 4'd14;
        tick;
        chk("rd_done", rdDone, 1);
        chk("rd_wr", rdEntry, EX);
        rdIndex = 4'd0;
        tick;
        chk("rd_idx0", rdEntry, 0);
        rdIndex = 4'd5;
        tick;
        chk("rd_dropped", rdEntry, 0);
        rdIndex = 4'd2;
        tick;
        rdReq = 0;
        chk("rd_cleared", rdEntry, 0);
        tick;
        chk("rd_idle", rdDone, 0);
        lookup(32'h00201123, 8'h00);
        chk("cleared_miss", miss, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
